ps2_receiver: RTL and testbench

PS/2 keyboard receive front-end for the CHIP-8 console. It samples the device-driven PS/2 clock and data lines and deframes 11-bit frames, checking start, parity and stop bits. It folds the E0 (extended) and F0 (break) prefixes into flags and emits one decoded scancode per key event as a single-cycle strobe. It sits directly upstream of the scancode-to-action keymap lookup and the PS/2 controller. It runs on the CPU-domain `clock` (fast_clock/4, 6.28125 MHz).

---
 rtl/ps2_receiver.sv | 169 ++++++++++++++++
 tb/tb_ps2_receiver.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receive front-end: synchronizes and filters the PS/2 lines, deframes
// 11-bit frames, folds E0/F0 prefixes into flags and strobes one scancode per key event.
module ps2_receiver #(
    parameter int FILTER_LENGTH  = 4,
    parameter int TIMEOUT_CYCLES = 12563
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       scancode_start,
    output logic       released,
    output logic       extended,
    output logic       error,
    output logic       busy
);

    localparam int FW = (FILTER_LENGTH > 1) ? $clog2(FILTER_LENGTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILTER_MAX  = FW'(FILTER_LENGTH - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, RECEIVE} state_t;

    state_t          state, state_next;
    logic [1:0]      clk_sync, data_sync;
    logic            filt_clk, filt_clk_prev;
    logic [FW-1:0]   filter_cnt;
    logic [3:0]      bit_cnt, bit_cnt_next;
    logic [TW-1:0]   timeout_cnt, timeout_cnt_next;
    logic [7:0]      shift_reg, shift_next;
    logic            parity_bit, parity_next;
    logic            ext_pending, ext_pending_next;
    logic            rel_pending, rel_pending_next;
    logic [7:0]      scancode_next;
    logic            released_next, extended_next, start_next, error_next;
    logic            sample, data_bit;

    // The filter counter restarts whenever the synchronized clock agrees with the
    // filtered one, so only an unbroken run of FILTER_LENGTH samples moves it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync      <= 2'b11;
            data_sync     <= 2'b11;
            filt_clk      <= 1'b1;
            filt_clk_prev <= 1'b1;
            filter_cnt    <= '0;
        end else begin
            clk_sync      <= {clk_sync[0], ps2_clock};
            data_sync     <= {data_sync[0], ps2_data};
            filt_clk_prev <= filt_clk;
            if (clk_sync[1] == filt_clk) begin
                filter_cnt <= '0;
            end else if (filter_cnt == FILTER_MAX) begin
                filt_clk   <= clk_sync[1];
                filter_cnt <= '0;
            end else begin
                filter_cnt <= filter_cnt + 1'b1;
            end
        end
    end

    assign sample   = filt_clk_prev & ~filt_clk;
    assign data_bit = data_sync[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            timeout_cnt    <= '0;
            shift_reg      <= '0;
            parity_bit     <= 1'b0;
            ext_pending    <= 1'b0;
            rel_pending    <= 1'b0;
            scancode       <= '0;
            released       <= 1'b0;
            extended       <= 1'b0;
            scancode_start <= 1'b0;
            error          <= 1'b0;
        end else begin
            state          <= state_next;
            bit_cnt        <= bit_cnt_next;
            timeout_cnt    <= timeout_cnt_next;
            shift_reg      <= shift_next;
            parity_bit     <= parity_next;
            ext_pending    <= ext_pending_next;
            rel_pending    <= rel_pending_next;
            scancode       <= scancode_next;
            released       <= released_next;
            extended       <= extended_next;
            scancode_start <= start_next;
            error          <= error_next;
        end
    end

    always_comb begin
        state_next       = state;
        bit_cnt_next     = bit_cnt;
        timeout_cnt_next = timeout_cnt;
        shift_next       = shift_reg;
        parity_next      = parity_bit;
        ext_pending_next = ext_pending;
        rel_pending_next = rel_pending;
        scancode_next    = scancode;
        released_next    = released;
        extended_next    = extended;
        start_next       = 1'b0;
        error_next       = 1'b0;
        case (state)
            IDLE: begin
                if (sample) begin
                    if (!data_bit) begin
                        state_next       = RECEIVE;
                        bit_cnt_next     = '0;
                        timeout_cnt_next = '0;
                    end else begin
                        error_next       = 1'b1;
                        ext_pending_next = 1'b0;
                        rel_pending_next = 1'b0;
                    end
                end
            end
            RECEIVE: begin
                if (sample) begin
                    timeout_cnt_next = '0;
                    bit_cnt_next     = bit_cnt + 1'b1;
                    if (bit_cnt < 4'd8) begin
                        shift_next = {data_bit, shift_reg[7:1]};
                    end else if (bit_cnt == 4'd8) begin
                        parity_next = data_bit;
                    end else begin
                        state_next = IDLE;
                        // Odd parity over data+parity, and a high stop bit.
                        if ((^{shift_reg, parity_bit}) && data_bit) begin
                            if (shift_reg == 8'hE0) begin
                                ext_pending_next = 1'b1;
                            end else if (shift_reg == 8'hF0) begin
                                rel_pending_next = 1'b1;
                            end else begin
                                scancode_next    = shift_reg;
                                released_next    = rel_pending;
                                extended_next    = ext_pending;
                                start_next       = 1'b1;
                                ext_pending_next = 1'b0;
                                rel_pending_next = 1'b0;
                            end
                        end else begin
                            error_next       = 1'b1;
                            ext_pending_next = 1'b0;
                            rel_pending_next = 1'b0;
                        end
                    end
                end else if (timeout_cnt == TIMEOUT_MAX) begin
                    state_next       = IDLE;
                    error_next       = 1'b1;
                    ext_pending_next = 1'b0;
                    rel_pending_next = 1'b0;
                end else begin
                    timeout_cnt_next = timeout_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RECEIVE);

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: PS/2 frames driven as waveforms, decoded events predicted
// from key-event rules and checked in order with exact stop-edge latency.
module tb_ps2_receiver;

    localparam int FL      = 4;
    localparam int TO      = 200;
    localparam int HALF    = 20;
    localparam int W       = 12;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clock;
    logic       ps2_data;
    logic [7:0] scancode;
    logic       scancode_start, released, extended, error, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stop_cyc = 0;

    // entry: [11] latency-checked, [10] error, [9] released, [8] extended, [7:0] code
    logic [W-1:0] exp_q[$];
    logic [9:0]   held;
    logic         rel_p, ext_p;

    ps2_receiver #(.FILTER_LENGTH(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
        .scancode(scancode), .scancode_start(scancode_start), .released(released),
        .extended(extended), .error(error), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Key-event rules: prefixes set flags, bad frames clear them, other bytes emit.
    task automatic model_frame(input logic [7:0] b, input logic good);
        if (!good) begin
            exp_q.push_back({1'b1, 1'b1, 10'd0});
            rel_p = 1'b0; ext_p = 1'b0;
        end else if (b == 8'hE0) begin
            ext_p = 1'b1;
        end else if (b == 8'hF0) begin
            rel_p = 1'b1;
        end else begin
            exp_q.push_back({1'b1, 1'b0, rel_p, ext_p, b});
            rel_p = 1'b0; ext_p = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [10:0] fb, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock) ps2_data = fb[i];
            repeat (HALF / 2) @(negedge clock);
            ps2_clock = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HALF) @(negedge clock);
            if (i == 5) check("busy_mid", busy, 1);
            ps2_clock = 1'b1;
            repeat (HALF / 2) @(negedge clock);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        model_frame(b, !bad_par && !bad_stop);
        send_bits({~bad_stop, par, b, 1'b0}, 11);
        check("busy_end", busy, 0);
    endtask

    // Event monitor: every strobe or error must match the next predicted event.
    always @(negedge clock) begin
        logic [W-1:0] e;
        if (!reset) begin
            held = '0;
        end else if (scancode_start || error) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {scancode_start, error}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                check("exclusive", scancode_start & error, 0);
                check("is_error", error, e[10]);
                if (!e[10]) begin
                    check("scancode", scancode, e[7:0]);
                    check("released", released, e[9]);
                    check("extended", extended, e[8]);
                    held = {e[7:0], e[9], e[8]};
                end
                if (e[11]) check("latency", cyc - stop_cyc, FL + 3);
            end
        end else begin
            check("hold", {scancode, released, extended}, held);
        end
    end

    initial begin
        logic [7:0] b;
        int r;
        reset = 1'b0; ps2_clock = 1'b1; ps2_data = 1'b1;
        rel_p = 1'b0; ext_p = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_outputs", {scancode, scancode_start, released, extended, error, busy}, 0);
        reset = 1'b1;
        repeat (10) @(negedge clock);

        // make, break, extended break then make
        send_frame(8'h1C, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        send_frame(8'h75, 0, 0);

        // parity error clears the pending release
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 1, 0);
        send_frame(8'h1C, 0, 0);

        // short glitch must be ignored
        @(negedge clock) ps2_clock = 1'b0;
        repeat (2) @(negedge clock);
        ps2_clock = 1'b1;
        repeat (12) @(negedge clock);
        check("glitch_busy", busy, 0);

        // timeout after 5 bits of a frame, then recovery
        exp_q.push_back({1'b0, 1'b1, 10'd0});
        rel_p = 1'b0; ext_p = 1'b0;
        send_bits({1'b1, 1'b1, 8'h55, 1'b0}, 5);
        check("busy_stall", busy, 1);
        repeat (TO + 60) @(negedge clock);
        check("busy_timeout", busy, 0);
        send_frame(8'h1C, 0, 0);

        // reset in the middle of a frame
        send_frame(8'h1C, 0, 0);
        send_bits({1'b1, 1'b0, 8'h33, 1'b0}, 5);
        reset = 1'b0;
        #1;
        check("midrst_outputs", {scancode, scancode_start, released, extended, error, busy}, 0);
        rel_p = 1'b0; ext_p = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        send_frame(8'h2D, 0, 0);

        // randomized key-event streams with short gaps
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 99);
            b = 8'($urandom_range(0, 255));
            if (b == 8'hE0 || b == 8'hF0) b = 8'h12;
            if (r < 12)      send_frame(8'hE0, 0, 0);
            else if (r < 28) send_frame(8'hF0, 0, 0);
            else if (r < 36) send_frame(b, 1, 0);
            else if (r < 41) send_frame(b, 0, 1);
            else             send_frame(b, 0, 0);
            repeat ($urandom_range(0, 30)) @(negedge clock);
        end

        repeat (50) @(negedge clock);
        check("events_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
